// File: rtl/memory_access_pkg.sv
// memory_access_pkg
//   Shared constants for the rv32i memory stage: one-hot opcode class
//   indices, exception bit indices (including the load/store misalign
//   bits), the load/store funct3 width codes, and the stage FSM states.
package memory_access_pkg;

  // One-hot opcode class vector
  localparam int OPCODE_WIDTH = 11;
  localparam int OP_RTYPE  = 0;
  localparam int OP_ITYPE  = 1;
  localparam int OP_LOAD   = 2;
  localparam int OP_STORE  = 3;
  localparam int OP_BRANCH = 4;
  localparam int OP_JAL    = 5;
  localparam int OP_JALR   = 6;
  localparam int OP_LUI    = 7;
  localparam int OP_AUIPC  = 8;
  localparam int OP_SYSTEM = 9;
  localparam int OP_FENCE  = 10;

  // Accumulated exception bit vector
  localparam int EXCEPTION_WIDTH = 6;
  localparam int ILLEGAL        = 0;
  localparam int ECALL          = 1;
  localparam int EBREAK         = 2;
  localparam int INSTR_MISALIGN = 3;
  localparam int LOAD_MISALIGN  = 4;
  localparam int STORE_MISALIGN = 5;

  // funct3 width/sign codes for loads and stores
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

  function automatic logic is_mem_op(input logic [OPCODE_WIDTH-1:0] opcode_type);
    return opcode_type[OP_LOAD] | opcode_type[OP_STORE];
  endfunction

endpackage

// File: rtl/memory_access_if.sv
// memory_access_if
//   Single-outstanding req/ack data-memory bus.
//   req/we/addr/wdata/sel : driven by the master (memory stage)
//   ack/rdata             : driven by the slave (data memory), rdata valid with ack
interface memory_access_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, sel, input ack, rdata);
  modport slave  (input req, we, addr, wdata, sel, output ack, rdata);
endinterface

// File: rtl/memory_access_lsu_align.sv
// lsu_align
//   Purely combinational byte-lane logic for the memory stage.
//   funct3, addr_lo, rs2_data -> sel, wdata (store lanes replicated)
//   funct3, addr_lo, rdata    -> load_data (sign/zero extended)
//   funct3, addr_lo           -> misaligned
module lsu_align
  import memory_access_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2_data,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Access size comes from funct3[1:0]; unused codes fall into the word case.
  always_comb begin
    sel        = 4'b1111;
    wdata      = rs2_data;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        sel   = 4'b0001 << addr_lo;
        wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        sel        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{rs2_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        sel        = 4'b1111;
        wdata      = rs2_data;
        misaligned = |addr_lo;
      end
    endcase
  end

  // Load extension picks the addressed lane, then extends by funct3.
  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LSU_B:   load_data = {{24{byte_lane[7]}}, byte_lane};
      LSU_H:   load_data = {{16{half_lane[15]}}, half_lane};
      LSU_BU:  load_data = {24'd0, byte_lane};
      LSU_HU:  load_data = {16'd0, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// memory_access
//   rv32i stage 4. Performs loads/stores over the dmem bus, passes every
//   other instruction through with one cycle of latency, and stalls the
//   upstream pipeline while a transaction or held result is pending.
//   clk, rst (async, active low)
//   execute_*  : instruction from execute
//   dmem       : data-memory bus (master side)
//   memory_*   : registered outputs to writeback
//   clk_en/stall/flush in, next_clk_en/next_stall out : pipeline control
module memory_access
  import memory_access_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [OPCODE_WIDTH-1:0]    execute_opcode_type,
  input  logic [2:0]                 execute_funct3,
  input  logic [31:0]                execute_result,
  input  logic [31:0]                execute_rs2_data,
  input  logic [4:0]                 execute_rd,
  input  logic                       execute_rd_wr_en,
  input  logic [31:0]                execute_rd_wr_data,
  input  logic                       execute_rd_valid,
  input  logic [31:0]                execute_pc,
  input  logic [EXCEPTION_WIDTH-1:0] execute_exception,
  memory_access_if.master            dmem,
  output logic [4:0]                 memory_rd,
  output logic                       memory_rd_wr_en,
  output logic [31:0]                memory_rd_wr_data,
  output logic                       memory_rd_valid,
  output logic [31:0]                memory_pc,
  output logic [OPCODE_WIDTH-1:0]    memory_opcode_type,
  output logic [EXCEPTION_WIDTH-1:0] memory_exception,
  input  logic                       clk_en,
  input  logic                       stall,
  input  logic                       flush,
  output logic                       next_clk_en,
  output logic                       next_stall
);

  mem_state_t state, state_next;

  logic                       accept;
  logic                       mem_op;
  logic                       is_load_op;
  logic                       drop;
  logic                       flush_pending;
  logic [2:0]                 saved_funct3;
  logic [1:0]                 saved_addr_lo;
  logic                       saved_is_load;
  logic [31:0]                hold_data;
  logic [31:0]                result_data;
  logic [EXCEPTION_WIDTH-1:0] misalign_exc;

  logic [2:0]  align_funct3;
  logic [1:0]  align_addr_lo;
  logic [3:0]  align_sel;
  logic [31:0] align_wdata;
  logic [31:0] align_load_data;
  logic        align_misaligned;

  // The aligner sees the incoming instruction in IDLE and the latched
  // access parameters while a transaction is outstanding.
  always_comb begin
    accept        = (state == IDLE) && clk_en && !stall && !flush;
    mem_op        = is_mem_op(execute_opcode_type);
    is_load_op    = execute_opcode_type[OP_LOAD];
    drop          = flush_pending || flush;
    align_funct3  = (state == IDLE) ? execute_funct3 : saved_funct3;
    align_addr_lo = (state == IDLE) ? execute_result[1:0] : saved_addr_lo;
    result_data   = saved_is_load ? align_load_data : memory_rd_wr_data;
    misalign_exc  = '0;
    if (is_load_op) misalign_exc[LOAD_MISALIGN]  = 1'b1;
    else            misalign_exc[STORE_MISALIGN] = 1'b1;
  end

  assign next_stall = stall || (state != IDLE);

  lsu_align u_lsu_align (
    .funct3     (align_funct3),
    .addr_lo    (align_addr_lo),
    .rs2_data   (execute_rs2_data),
    .rdata      (dmem.rdata),
    .sel        (align_sel),
    .wdata      (align_wdata),
    .load_data  (align_load_data),
    .misaligned (align_misaligned)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state: a flushed transaction still waits for its ack, then drops.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && mem_op && !align_misaligned) state_next = BUSY;
      BUSY: if (dmem.ack) state_next = (stall && !drop) ? HOLD : IDLE;
      HOLD: if (drop || !stall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pipeline and bus registers. next_clk_en is a one-cycle pulse per result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem.req           <= 1'b0;
      dmem.we            <= 1'b0;
      dmem.addr          <= '0;
      dmem.wdata         <= '0;
      dmem.sel           <= '0;
      memory_rd          <= '0;
      memory_rd_wr_en    <= 1'b0;
      memory_rd_wr_data  <= '0;
      memory_rd_valid    <= 1'b0;
      memory_pc          <= '0;
      memory_opcode_type <= '0;
      memory_exception   <= '0;
      next_clk_en        <= 1'b0;
      saved_funct3       <= '0;
      saved_addr_lo      <= '0;
      saved_is_load      <= 1'b0;
      hold_data          <= '0;
      flush_pending      <= 1'b0;
    end else begin
      next_clk_en <= 1'b0;

      if (state != IDLE && state_next == IDLE) flush_pending <= 1'b0;
      else if (state != IDLE && flush)         flush_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            memory_rd          <= execute_rd;
            memory_rd_wr_en    <= execute_rd_wr_en;
            memory_rd_wr_data  <= execute_rd_wr_data;
            memory_rd_valid    <= execute_rd_valid;
            memory_pc          <= execute_pc;
            memory_opcode_type <= execute_opcode_type;
            memory_exception   <= execute_exception;
            if (!mem_op) begin
              next_clk_en <= 1'b1;
            end else if (align_misaligned) begin
              memory_rd_wr_en  <= 1'b0;
              memory_exception <= execute_exception | misalign_exc;
              next_clk_en      <= 1'b1;
            end else begin
              dmem.req        <= 1'b1;
              dmem.we         <= execute_opcode_type[OP_STORE];
              dmem.addr       <= {execute_result[31:2], 2'b00};
              dmem.wdata      <= align_wdata;
              dmem.sel        <= align_sel;
              saved_funct3    <= execute_funct3;
              saved_addr_lo   <= execute_result[1:0];
              saved_is_load   <= is_load_op;
              memory_rd_valid <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (dmem.ack) begin
            dmem.req <= 1'b0;
            if (!drop) begin
              if (!stall) begin
                memory_rd_wr_data <= result_data;
                memory_rd_valid   <= 1'b1;
                next_clk_en       <= 1'b1;
              end else begin
                hold_data <= result_data;
              end
            end
          end
        end
        HOLD: begin
          if (!drop && !stall) begin
            memory_rd_wr_data <= hold_data;
            memory_rd_valid   <= 1'b1;
            next_clk_en       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access
//   Directed-vector bench for the memory stage with hand-computed results.
module tb_memory_access;
  import memory_access_pkg::*;

  localparam logic [OPCODE_WIDTH-1:0] OPC_ADD   = OPCODE_WIDTH'(1) << OP_RTYPE;
  localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD  = OPCODE_WIDTH'(1) << OP_LOAD;
  localparam logic [OPCODE_WIDTH-1:0] OPC_STORE = OPCODE_WIDTH'(1) << OP_STORE;

  logic                       clk;
  logic                       rst;
  logic [OPCODE_WIDTH-1:0]    execute_opcode_type;
  logic [2:0]                 execute_funct3;
  logic [31:0]                execute_result;
  logic [31:0]                execute_rs2_data;
  logic [4:0]                 execute_rd;
  logic                       execute_rd_wr_en;
  logic [31:0]                execute_rd_wr_data;
  logic                       execute_rd_valid;
  logic [31:0]                execute_pc;
  logic [EXCEPTION_WIDTH-1:0] execute_exception;
  logic [4:0]                 memory_rd;
  logic                       memory_rd_wr_en;
  logic [31:0]                memory_rd_wr_data;
  logic                       memory_rd_valid;
  logic [31:0]                memory_pc;
  logic [OPCODE_WIDTH-1:0]    memory_opcode_type;
  logic [EXCEPTION_WIDTH-1:0] memory_exception;
  logic                       clk_en;
  logic                       stall;
  logic                       flush;
  logic                       next_clk_en;
  logic                       next_stall;

  int total;
  int bad;

  memory_access_if dmem_bus ();

  memory_access dut (
    .clk                 (clk),
    .rst                 (rst),
    .execute_opcode_type (execute_opcode_type),
    .execute_funct3      (execute_funct3),
    .execute_result      (execute_result),
    .execute_rs2_data    (execute_rs2_data),
    .execute_rd          (execute_rd),
    .execute_rd_wr_en    (execute_rd_wr_en),
    .execute_rd_wr_data  (execute_rd_wr_data),
    .execute_rd_valid    (execute_rd_valid),
    .execute_pc          (execute_pc),
    .execute_exception   (execute_exception),
    .dmem                (dmem_bus),
    .memory_rd           (memory_rd),
    .memory_rd_wr_en     (memory_rd_wr_en),
    .memory_rd_wr_data   (memory_rd_wr_data),
    .memory_rd_valid     (memory_rd_valid),
    .memory_pc           (memory_pc),
    .memory_opcode_type  (memory_opcode_type),
    .memory_exception    (memory_exception),
    .clk_en              (clk_en),
    .stall               (stall),
    .flush               (flush),
    .next_clk_en         (next_clk_en),
    .next_stall          (next_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Presents one instruction with clk_en high for exactly one edge.
  task automatic applyStimulus(input logic [OPCODE_WIDTH-1:0] op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rs2,
                               input logic [4:0] rd, input logic wr_en, input logic [31:0] wr_data,
                               input logic [31:0] pc, input logic [EXCEPTION_WIDTH-1:0] exc);
    execute_opcode_type = op;
    execute_funct3      = f3;
    execute_result      = addr;
    execute_rs2_data    = rs2;
    execute_rd          = rd;
    execute_rd_wr_en    = wr_en;
    execute_rd_wr_data  = wr_data;
    execute_rd_valid    = (op == OPC_ADD);
    execute_pc          = pc;
    execute_exception   = exc;
    clk_en              = 1'b1;
    tick();
    clk_en              = 1'b0;
  endtask

  task automatic doLoad(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] rdata, input logic [3:0] exp_sel, input logic [31:0] exp_data);
    applyStimulus(OPC_LOAD, f3, addr, 32'h0, 5'd7, 1'b1, 32'h0, 32'h200, '0);
    checkOutput({tag, "_req"}, 32'(dmem_bus.req), 32'd1);
    checkOutput({tag, "_sel"}, 32'(dmem_bus.sel), 32'(exp_sel));
    checkOutput({tag, "_addr"}, dmem_bus.addr, {addr[31:2], 2'b00});
    dmem_bus.ack   = 1'b1;
    dmem_bus.rdata = rdata;
    tick();
    dmem_bus.ack   = 1'b0;
    checkOutput({tag, "_data"}, memory_rd_wr_data, exp_data);
    checkOutput({tag, "_nce"}, 32'(next_clk_en), 32'd1);
    checkOutput({tag, "_valid"}, 32'(memory_rd_valid), 32'd1);
    checkOutput({tag, "_reqlow"}, 32'(dmem_bus.req), 32'd0);
  endtask

  task automatic doStore(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [3:0] exp_sel, input logic [31:0] exp_wdata);
    applyStimulus(OPC_STORE, f3, addr, rs2, 5'd0, 1'b0, 32'h0, 32'h300, '0);
    checkOutput({tag, "_we"}, 32'(dmem_bus.we), 32'd1);
    checkOutput({tag, "_sel"}, 32'(dmem_bus.sel), 32'(exp_sel));
    checkOutput({tag, "_wdata"}, dmem_bus.wdata, exp_wdata);
    dmem_bus.ack = 1'b1;
    tick();
    dmem_bus.ack = 1'b0;
    checkOutput({tag, "_nce"}, 32'(next_clk_en), 32'd1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0;
    clk_en = 1'b0; stall = 1'b0; flush = 1'b0;
    execute_opcode_type = '0; execute_funct3 = '0; execute_result = '0;
    execute_rs2_data = '0; execute_rd = '0; execute_rd_wr_en = 1'b0;
    execute_rd_wr_data = '0; execute_rd_valid = 1'b0; execute_pc = '0;
    execute_exception = '0;
    dmem_bus.ack = 1'b0; dmem_bus.rdata = '0;

    tick(); tick();
    checkOutput("rst_req", 32'(dmem_bus.req), 32'd0);
    checkOutput("rst_nce", 32'(next_clk_en), 32'd0);
    checkOutput("rst_data", memory_rd_wr_data, 32'd0);
    checkOutput("rst_nstall", 32'(next_stall), 32'd0);
    rst = 1'b1;
    tick();

    // ADD passthrough
    applyStimulus(OPC_ADD, 3'b000, 32'h55, 32'h0, 5'd5, 1'b1, 32'h1234, 32'h40, '0);
    checkOutput("add_nce", 32'(next_clk_en), 32'd1);
    checkOutput("add_data", memory_rd_wr_data, 32'h1234);
    checkOutput("add_rd", 32'(memory_rd), 32'd5);
    checkOutput("add_pc", memory_pc, 32'h40);
    checkOutput("add_req", 32'(dmem_bus.req), 32'd0);
    tick();
    checkOutput("add_nce_pulse", 32'(next_clk_en), 32'd0);

    // SW to 0x100, ack after two wait cycles
    applyStimulus(OPC_STORE, LSU_W, 32'h100, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 32'h44, '0);
    checkOutput("sw_sel", 32'(dmem_bus.sel), 32'hF);
    checkOutput("sw_addr", dmem_bus.addr, 32'h100);
    checkOutput("sw_wdata", dmem_bus.wdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      checkOutput("sw_req_held", 32'(dmem_bus.req), 32'd1);
      checkOutput("sw_nstall", 32'(next_stall), 32'd1);
      checkOutput("sw_nce_busy", 32'(next_clk_en), 32'd0);
      if (i == 2) dmem_bus.ack = 1'b1;
      tick();
    end
    dmem_bus.ack = 1'b0;
    checkOutput("sw_req_drop", 32'(dmem_bus.req), 32'd0);
    checkOutput("sw_nce", 32'(next_clk_en), 32'd1);
    checkOutput("sw_nstall_idle", 32'(next_stall), 32'd0);

    // Load extension table
    doLoad("lb",  LSU_B,  32'h103, 32'h80FFFF7F, 4'b1000, 32'hFFFFFF80);
    doLoad("lbu", LSU_BU, 32'h103, 32'h80FFFF7F, 4'b1000, 32'h00000080);
    doLoad("lb0", LSU_B,  32'h100, 32'h80FFFF7F, 4'b0001, 32'h0000007F);
    doLoad("lh",  LSU_H,  32'h102, 32'h80FFFF7F, 4'b1100, 32'hFFFF80FF);
    doLoad("lhu", LSU_HU, 32'h102, 32'h80FFFF7F, 4'b1100, 32'h000080FF);
    doLoad("lhl", LSU_H,  32'h100, 32'h80FF7F7F, 4'b0011, 32'h00007F7F);
    doLoad("lw",  LSU_W,  32'h104, 32'h80FFFF7F, 4'b1111, 32'h80FFFF7F);
    doLoad("l111", 3'b111, 32'h108, 32'h13579BDF, 4'b1111, 32'h13579BDF);

    // Store lane replication
    doStore("sb", LSU_B, 32'h102, 32'h12345678, 4'b0100, 32'h78787878);
    doStore("sh", LSU_H, 32'h102, 32'h12345678, 4'b1100, 32'h56785678);

    // Misaligned LH and SW
    applyStimulus(OPC_LOAD, LSU_H, 32'h101, 32'h0, 5'd9, 1'b1, 32'h0, 32'h50, '0);
    checkOutput("mis_lh_req", 32'(dmem_bus.req), 32'd0);
    checkOutput("mis_lh_exc", 32'(memory_exception), 32'h10);
    checkOutput("mis_lh_wren", 32'(memory_rd_wr_en), 32'd0);
    checkOutput("mis_lh_nce", 32'(next_clk_en), 32'd1);
    checkOutput("mis_lh_nstall", 32'(next_stall), 32'd0);
    applyStimulus(OPC_STORE, LSU_W, 32'h102, 32'h0, 5'd0, 1'b0, 32'h0, 32'h54, 6'h01);
    checkOutput("mis_sw_req", 32'(dmem_bus.req), 32'd0);
    checkOutput("mis_sw_exc", 32'(memory_exception), 32'h21);
    checkOutput("mis_sw_nce", 32'(next_clk_en), 32'd1);

    // LW whose ack lands while writeback stalls for three cycles
    applyStimulus(OPC_LOAD, LSU_W, 32'h200, 32'h0, 5'd3, 1'b1, 32'h0, 32'h58, '0);
    stall = 1'b1;
    dmem_bus.ack = 1'b1;
    dmem_bus.rdata = 32'hCAFEF00D;
    tick();
    dmem_bus.ack = 1'b0;
    dmem_bus.rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold_req", 32'(dmem_bus.req), 32'd0);
      checkOutput("hold_nce", 32'(next_clk_en), 32'd0);
      checkOutput("hold_nstall", 32'(next_stall), 32'd1);
      if (i == 2) stall = 1'b0;
      else        tick();
    end
    checkOutput("hold_nstall_release", 32'(next_stall), 32'd1);
    tick();
    checkOutput("hold_data", memory_rd_wr_data, 32'hCAFEF00D);
    checkOutput("hold_out_nce", 32'(next_clk_en), 32'd1);
    checkOutput("hold_out_req", 32'(dmem_bus.req), 32'd0);
    checkOutput("hold_out_nstall", 32'(next_stall), 32'd0);

    // Flush during BUSY of an SW
    applyStimulus(OPC_STORE, LSU_W, 32'h300, 32'hA5A5A5A5, 5'd0, 1'b0, 32'h0, 32'h5C, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("flush_req1", 32'(dmem_bus.req), 32'd1);
    tick();
    checkOutput("flush_req2", 32'(dmem_bus.req), 32'd1);
    dmem_bus.ack = 1'b1;
    tick();
    dmem_bus.ack = 1'b0;
    checkOutput("flush_reqlow", 32'(dmem_bus.req), 32'd0);
    checkOutput("flush_nce", 32'(next_clk_en), 32'd0);
    checkOutput("flush_nstall", 32'(next_stall), 32'd0);
    applyStimulus(OPC_ADD, 3'b000, 32'h0, 32'h0, 5'd6, 1'b1, 32'h777, 32'h60, '0);
    checkOutput("flush_next_nce", 32'(next_clk_en), 32'd1);
    checkOutput("flush_next_data", memory_rd_wr_data, 32'h777);

    // Upstream stall and flush in IDLE hold outputs; stray ack ignored
    stall = 1'b1;
    applyStimulus(OPC_ADD, 3'b000, 32'h0, 32'h0, 5'd8, 1'b1, 32'h999, 32'h64, '0);
    checkOutput("idle_stall_nce", 32'(next_clk_en), 32'd0);
    checkOutput("idle_stall_data", memory_rd_wr_data, 32'h777);
    checkOutput("idle_stall_nstall", 32'(next_stall), 32'd1);
    stall = 1'b0;
    flush = 1'b1;
    applyStimulus(OPC_LOAD, LSU_W, 32'h400, 32'h0, 5'd8, 1'b1, 32'h0, 32'h68, '0);
    flush = 1'b0;
    checkOutput("idle_flush_req", 32'(dmem_bus.req), 32'd0);
    checkOutput("idle_flush_nce", 32'(next_clk_en), 32'd0);
    dmem_bus.ack = 1'b1;
    tick();
    dmem_bus.ack = 1'b0;
    checkOutput("idle_ack_req", 32'(dmem_bus.req), 32'd0);
    checkOutput("idle_ack_nce", 32'(next_clk_en), 32'd0);

    // Asynchronous reset mid-BUSY
    applyStimulus(OPC_LOAD, LSU_W, 32'h500, 32'h0, 5'd4, 1'b1, 32'h0, 32'h6C, '0);
    checkOutput("rstb_req_before", 32'(dmem_bus.req), 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("rstb_req", 32'(dmem_bus.req), 32'd0);
    checkOutput("rstb_rd", 32'(memory_rd), 32'd4 & 32'd0);
    checkOutput("rstb_pc", memory_pc, 32'd0);
    checkOutput("rstb_data", memory_rd_wr_data, 32'd0);
    checkOutput("rstb_sel", 32'(dmem_bus.sel), 32'd0);
    checkOutput("rstb_nstall", 32'(next_stall), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    applyStimulus(OPC_ADD, 3'b000, 32'h0, 32'h0, 5'd2, 1'b1, 32'hBEEF, 32'h70, '0);
    checkOutput("rsta_nce", 32'(next_clk_en), 32'd1);
    checkOutput("rsta_data", memory_rd_wr_data, 32'hBEEF);
    checkOutput("rsta_req", 32'(dmem_bus.req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_access.md
# memory_access

Stage 4 of the rv32i pipeline. It sits between execute and writeback and performs every LOAD and STORE over a single-outstanding req/ack data-memory bus. It sign- or zero-extends load data and raises misaligned-address exceptions. Every other instruction passes through with one cycle of latency. While a bus transaction or a held result is pending, it stalls the upstream pipeline.

## Interface
Parameters: none. All widths come from `rv32i_header.vh`: `OPCODE_WIDTH`, `EXCEPTION_WIDTH`, and the opcode and exception bit indices.

Clock and reset:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset

From execute:
- execute_opcode_type  in  `OPCODE_WIDTH`  one-hot opcode class
- execute_funct3  in  3  memory width/sign select
- execute_result  in  32  effective address, or ALU result for non-memory ops
- execute_rs2_data  in  32  store data
- execute_rd  in  5  destination register
- execute_rd_wr_en  in  1  destination write enable
- execute_rd_wr_data  in  32  writeback data for non-memory ops
- execute_rd_valid  in  1  writeback data is already valid
- execute_pc  in  32  instruction PC
- execute_exception  in  `EXCEPTION_WIDTH`  accumulated exception bits

Data-memory bus:
- dmem_req  out  1  registered request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  store data, lane-replicated
- dmem_sel  out  4  byte-lane enables
- dmem_ack  in  1  transaction complete
- dmem_rdata  in  32  read data, valid with ack

To writeback (all registered):
- memory_rd  out  5  destination register
- memory_rd_wr_en  out  1  destination write enable
- memory_rd_wr_data  out  32  writeback data
- memory_rd_valid  out  1  writeback data valid
- memory_pc  out  32  instruction PC
- memory_opcode_type  out  `OPCODE_WIDTH`  opcode class
- memory_exception  out  `EXCEPTION_WIDTH`  exception bits

Pipeline control:
- clk_en  in  1  stage enable from execute
- stall  in  1  stall from writeback
- flush  in  1  flush this stage
- next_clk_en  out  1  registered enable for writeback
- next_stall  out  1  combinational stall to execute

## Operation
- FSM states: IDLE, BUSY (request outstanding), HOLD (ack received while `stall` high; rdata buffered).
- Accept condition, IDLE only: `clk_en && !stall && !flush`.
  - Non-memory op: all memory_* outputs load from the execute_* inputs; next_clk_en<=1.
  - Aligned LOAD/STORE: drive dmem_* registered, dmem_req<=1, go to BUSY; next_clk_en<=0.
- Misaligned access means halfword with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request is made. memory_exception <= execute_exception | `LOAD_MISALIGN` or `STORE_MISALIGN` bit.
  - memory_rd_wr_en<=0; passes through in 1 cycle.
- Store funct3 000/001/010:
  - SB: wdata={4{rs2[7:0]}}, sel=4'b0001<<addr[1:0]
  - SH: wdata={2{rs2[15:0]}}, sel=addr[1]?1100:0011
  - SW: sel=1111
- Load funct3:
  - 000 LB, 001 LH: sign-extend the selected lane
  - 100 LBU, 101 LHU: zero-extend the selected lane
  - 010 LW, and the unused codes 011/110/111: full word
- dmem_we is 1 for stores; load sel is computed the same way as for stores.
- BUSY with dmem_ack=1:
  - dmem_req<=0.
  - If `stall`=0: memory_rd_wr_data<=extended load (or unchanged for store), memory_rd_valid<=1, next_clk_en<=1, go to IDLE.
  - If `stall`=1: buffer the extended data and go to HOLD.
- HOLD: when `stall` falls, present the buffered result with next_clk_en<=1 and go to IDLE.
- next_stall = `stall` || state!=IDLE.
- Flush:
  - In IDLE: next_clk_en<=0, no request.
  - In BUSY/HOLD: the transaction is never aborted. It completes, then the result is discarded (next_clk_en<=0, go to IDLE).
- Upstream `stall` with state IDLE holds every output register; next_clk_en<=0.

## Timing
- Reset values: all outputs 0; state IDLE. dmem_req drops immediately on reset assertion, including mid-transaction.
- Non-memory op: output 1 cycle after acceptance.
- Memory op: dmem_req is high the cycle after acceptance and stays high until the cycle ack is sampled. The result is valid on the edge that samples ack.
  - With ack in the first BUSY cycle, the result appears 2 cycles after acceptance.
- dmem_addr, dmem_we, dmem_sel and dmem_wdata are stable while dmem_req=1.
- At most one outstanding request. dmem_ack while in IDLE is ignored.

## Structure
- `rv32i_header.vh` gains `LOAD_MISALIGN` and `STORE_MISALIGN` exception indices and the funct3 width constants `LSU_B`, `LSU_H`, `LSU_W`, `LSU_BU`, `LSU_HU`.
- One combinational sub-module, `lsu_align`, computes:
  - sel and replicated wdata from (funct3, addr[1:0], rs2)
  - extended load data from (funct3, addr[1:0], rdata)
  - the misaligned flag
- The FSM and pipeline registers live in `memory_access`.

## Test plan
- SW to 0x100 with rs2=0xDEADBEEF, ack after 2 wait cycles:
  - sel=1111, dmem_req held 3 cycles, next_stall high throughout
  - next_clk_en=1 the cycle after ack
- LB from 0x103 with rdata=0x80FF_FF7F: memory_rd_wr_data=0xFFFFFF80. Repeat with LBU: 0x00000080.
- LH from 0x101: no dmem_req, LOAD_MISALIGN set, memory_rd_wr_en=0, 1-cycle latency.
- LW whose ack arrives with `stall`=1 for 3 cycles:
  - state HOLD, data buffered
  - output appears the cycle after `stall` falls; no second request issued
- Flush asserted during BUSY of an SW:
  - dmem_req stays high until ack
  - then next_clk_en=0 and the next instruction is accepted from IDLE
- rst low mid-BUSY: dmem_req=0 and all outputs 0 asynchronously; after release a normal ADD passes in 1 cycle.
